// File: rtl/timer_count_reg.sv
`default_nettype none
// ============================================================================
// Module      : timer_count_reg
// Description : 8-bit stopwatch/timer count register with a small run-control
//               FSM. Up counting takes its next value from an external
//               incrementor (inc_result), and down counting decrements
//               internally. Optional macro TIMER_LIMIT_EN adds an up-count
//               terminal value LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_count_reg #(
    parameter logic [7:0] LIMIT = 8'd59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       mode,
    input  logic [7:0] inc_result,
    output logic [7:0] count,
    output logic [1:0] state,
    output logic       mode_q,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_count;
    logic [7:0] w_count_nxt;
    logic       r_mode_q;
    logic       w_mode_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       r_wrap;
    logic       w_wrap_nxt;
    logic       w_up_limit_hit;

`ifdef TIMER_LIMIT_EN
    // Terminal value reached: roll to zero instead of taking the incrementor.
    assign w_up_limit_hit = (r_count == LIMIT);
`else
    // Without a limit the count only rolls over naturally at 255.
    logic w_unused_limit;
    assign w_unused_limit = ^LIMIT;
    assign w_up_limit_hit = 1'b0;
`endif

    // State registers; reset overrides every other input including a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= 8'd0;
            r_mode_q <= 1'b0;
            r_done   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_mode_q <= w_mode_nxt;
            r_done   <= w_done_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    // Next-state decode in priority order clear > load > stop > start > tick.
    // An asserted input that is ignored in the current state still masks
    // every lower-priority input for that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode_q;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (clear) begin
            w_count_nxt = 8'd0;
            w_state_nxt = ST_IDLE;
        end else if (load) begin
            if (r_state != ST_RUN) begin
                w_count_nxt = load_val;
                w_state_nxt = ST_IDLE;
            end
        end else if (stop) begin
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_PAUSE;
            end
        end else if (start) begin
            if ((r_state == ST_IDLE) || (r_state == ST_PAUSE)) begin
                w_mode_nxt = mode;
                if (mode && (r_count == 8'd0)) begin
                    // Nothing left to count down: expire immediately.
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
        end else if (tick && (r_state == ST_RUN)) begin
            if (!r_mode_q) begin
                if (w_up_limit_hit) begin
                    w_count_nxt = 8'd0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = inc_result;
                    w_wrap_nxt  = (r_count == 8'hFF);
                end
            end else if (r_count <= 8'd1) begin
                w_count_nxt = 8'd0;
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
            end else begin
                w_count_nxt = r_count - 8'd1;
            end
        end
    end

    assign count  = r_count;
    assign state  = r_state;
    assign mode_q = r_mode_q;
    assign done   = r_done;
    assign wrap   = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_timer_count_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_count_reg
// Description : Directed scoreboard bench for timer_count_reg. The stimulus
//               process queues the expected post-edge outputs and a monitor
//               compares them one edge at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_count_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       mode = 1'b0;
    logic [7:0] inc_result;
    logic [7:0] count;
    logic [1:0] state;
    logic       mode_q;
    logic       done;
    logic       wrap;

    typedef struct {
        logic [7:0] c;
        logic [1:0] s;
        logic       m;
        logic       d;
        logic       w;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    timer_count_reg #(.LIMIT(8'd59)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .load_val(load_val), .mode(mode),
        .inc_result(inc_result), .count(count), .state(state),
        .mode_q(mode_q), .done(done), .wrap(wrap)
    );

    // External incrementor that the count register relies on.
    assign inc_result = count + 8'd1;

    always #5 clk = ~clk;

    // Monitor: one expected snapshot per queued edge, compared after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (count === e.c && state === e.s && mode_q === e.m &&
                done === e.d && wrap === e.w) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL %s: got count=%0d state=%0d mode_q=%0b done=%0b wrap=%0b, required count=%0d state=%0d mode_q=%0b done=%0b wrap=%0b",
                         e.name, count, state, mode_q, done, wrap,
                         e.c, e.s, e.m, e.d, e.w);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string nm, input bit r, input bit cl, input bit ld,
                        input logic [7:0] lv, input bit sp, input bit st,
                        input bit md, input bit tk,
                        input logic [7:0] ec, input logic [1:0] es,
                        input bit em, input bit ed, input bit ew);
        exp_t e;
        @(negedge clk);
        rst = r; clear = cl; load = ld; load_val = lv; stop = sp;
        start = st; mode = md; tick = tk;
        e.c = ec; e.s = es; e.m = em; e.d = ed; e.w = ew; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        //    name            rst cl ld lv     sp st md tk  count  st  mq d  w
        step("reset",          1, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0,   0, 0, 0, 0);
        step("start_up",       0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd0,   1, 0, 0, 0);
        step("up_tick1",       0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd1,   1, 0, 0, 0);
        step("up_tick2",       0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd2,   1, 0, 0, 0);
        step("up_tick3",       0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd3,   1, 0, 0, 0);
        step("hold_no_tick",   0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd3,   1, 0, 0, 0);
        step("up_tick4",       0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd4,   1, 0, 0, 0);
        step("up_tick5",       0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd5,   1, 0, 0, 0);
        step("up_tick6",       0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd6,   1, 0, 0, 0);
        step("up_tick7",       0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd7,   1, 0, 0, 0);
        step("stop_with_tick", 0, 0, 0, 8'd0,  1, 0, 0, 1, 8'd7,   2, 0, 0, 0);
        step("pause_tick",     0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd7,   2, 0, 0, 0);
        step("resume",         0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd7,   1, 0, 0, 0);
        step("resume_tick",    0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd8,   1, 0, 0, 0);
        step("clear_run",      0, 1, 0, 8'd0,  0, 0, 0, 1, 8'd0,   0, 0, 0, 0);
        step("load40",         0, 0, 1, 8'd40, 0, 0, 0, 0, 8'd40,  0, 0, 0, 0);
        step("start40",        0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd40,  1, 0, 0, 0);
        step("load_in_run",    0, 0, 1, 8'd5,  0, 0, 0, 1, 8'd40,  1, 0, 0, 0);
        step("rst_with_tick",  1, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0,   0, 0, 0, 0);
        step("load3",          0, 0, 1, 8'd3,  0, 0, 0, 0, 8'd3,   0, 0, 0, 0);
        step("start_down",     0, 0, 0, 8'd0,  0, 1, 1, 0, 8'd3,   1, 1, 0, 0);
        step("down_tick1",     0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd2,   1, 1, 0, 0);
        step("down_tick2",     0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd1,   1, 1, 0, 0);
        step("down_expire",    0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0,   3, 1, 1, 0);
        step("done_one_cycle", 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0,   3, 1, 0, 0);
        step("done_tick",      0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0,   3, 1, 0, 0);
        step("done_start_ign", 0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd0,   3, 1, 0, 0);
        step("done_stop_ign",  0, 0, 0, 8'd0,  1, 0, 0, 0, 8'd0,   3, 1, 0, 0);
        step("load0",          0, 0, 1, 8'd0,  0, 0, 0, 0, 8'd0,   0, 1, 0, 0);
        step("start_down_0",   0, 0, 0, 8'd0,  0, 1, 1, 0, 8'd0,   3, 1, 1, 0);
        step("done0_pulse",    0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0,   3, 1, 0, 0);
        step("clear_done",     0, 1, 0, 8'd0,  0, 0, 0, 0, 8'd0,   0, 1, 0, 0);
        step("start_stop_idl", 0, 0, 0, 8'd0,  1, 1, 0, 0, 8'd0,   0, 1, 0, 0);
        step("stop_idle_ign",  0, 0, 0, 8'd0,  1, 0, 0, 1, 8'd0,   0, 1, 0, 0);
        step("tick_idle_ign",  0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0,   0, 1, 0, 0);
`ifdef TIMER_LIMIT_EN
        step("load59",         0, 0, 1, 8'd59, 0, 0, 0, 0, 8'd59,  0, 1, 0, 0);
        step("start_up59",     0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd59,  1, 0, 0, 0);
        step("limit_wrap",     0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0,   1, 0, 0, 1);
        step("wrap_one_cycle", 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0,   1, 0, 0, 0);
        step("load200",        0, 0, 0, 8'd0,  1, 0, 0, 0, 8'd0,   2, 0, 0, 0);
        step("load_over",      0, 0, 1, 8'd255,0, 0, 0, 0, 8'd255, 0, 0, 0, 0);
        step("start_over",     0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd255, 1, 0, 0, 0);
        step("over_wrap",      0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0,   1, 0, 0, 1);
`else
        step("load254",        0, 0, 1, 8'd254,0, 0, 0, 0, 8'd254, 0, 1, 0, 0);
        step("start_up254",    0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd254, 1, 0, 0, 0);
        step("tick_to_255",    0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd255, 1, 0, 0, 0);
        step("rollover_wrap",  0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0,   1, 0, 0, 1);
        step("wrap_one_cycle", 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0,   1, 0, 0, 0);
        step("load59",         0, 0, 0, 8'd0,  1, 0, 0, 0, 8'd0,   2, 0, 0, 0);
        step("load59b",        0, 0, 1, 8'd59, 0, 0, 0, 0, 8'd59,  0, 0, 0, 0);
        step("start59",        0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd59,  1, 0, 0, 0);
        step("no_limit_59",    0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd60,  1, 0, 0, 0);
`endif
        step("final_reset",    1, 0, 0, 8'd0,  0, 1, 1, 1, 8'd0,   0, 0, 0, 0);

        @(negedge clk);
        rst = 1'b0; tick = 1'b0; start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks = n_checks + 1;
            $display("FAIL drain: %0d expected entries left unchecked, required 0",
                     exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_count_reg.md
TIMER_COUNT_REG -- requirements
Module: timer_count_reg

Interface
REQ-001 SHALL have parameter LIMIT, default 8'd59, up-count terminal value (used only when TIMER_LIMIT_EN is defined).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port tick  input  1  one-cycle count-enable pulse from the prescaler.
REQ-005 SHALL have port start  input  1  run request.
REQ-006 SHALL have port stop  input  1  pause request.
REQ-007 SHALL have port clear  input  1  zero the count and return to IDLE.
REQ-008 SHALL have port load  input  1  preset request.
REQ-009 SHALL have port load_val  input  8  preset value.
REQ-010 SHALL have port mode  input  1  0 = count up (stopwatch), 1 = count down (timer); sampled on start only.
REQ-011 SHALL have port inc_result  input  8  result returned by the external 8-bit incrementor.
REQ-012 SHALL have port count  output  8  registered count; also the incrementor's input.
REQ-013 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-014 SHALL have port mode_q  output  1  mode latched at the last accepted start.
REQ-015 SHALL have port done  output  1  one-cycle pulse on countdown expiry.
REQ-016 SHALL have port wrap  output  1  one-cycle pulse on up-count rollover.

Function
REQ-017 Per-cycle priority SHALL be: rst > clear > load > stop > start > tick.
REQ-018 clear SHALL set count=0, state=IDLE on the next edge, from any state.
REQ-019 load in IDLE, PAUSE or DONE SHALL set count=load_val, state=IDLE; load in RUN SHALL be ignored.
REQ-020 start in IDLE or PAUSE SHALL move to RUN and latch mode into mode_q; start in RUN or DONE SHALL be ignored.
REQ-021 stop in RUN SHALL move to PAUSE with count held; stop in any other state SHALL be ignored; start and stop together SHALL act as stop only.
REQ-022 tick SHALL be honoured only in RUN when no higher-priority input is asserted; otherwise count SHALL hold.
REQ-023 Up mode tick SHALL set count=inc_result on the same edge (one-cycle latency, no internal adder).
REQ-024 Down mode tick SHALL set count=count-1; when count==1 it SHALL set count=0, state=DONE and pulse done for that one cycle.
REQ-025 start in down mode with count==0 SHALL go directly to DONE and pulse done for one cycle.
REQ-026 DONE SHALL be left only by clear, load or rst; count SHALL hold 0.
REQ-027 done and wrap SHALL be registered, high exactly one cycle, never both high in the same cycle.
REQ-028 count SHALL never change except by rst, clear, load or an honoured tick.

Reset
REQ-029 rst SHALL, on the next edge, set count=0, state=IDLE, mode_q=0, done=0, wrap=0, overriding all inputs including a mid-run tick.

Configuration
REQ-030 Macro TIMER_LIMIT_EN defined: an up-mode tick with count==LIMIT SHALL set count=0 and pulse wrap, state stays RUN.
REQ-031 Macro TIMER_LIMIT_EN undefined: an up-mode tick with count==255 SHALL take inc_result (0) and pulse wrap, state stays RUN; LIMIT is unused.
REQ-032 If TIMER_LIMIT_EN is defined and count exceeds LIMIT (by load), up ticks SHALL continue via inc_result until 255->0 wraps with wrap pulse.

Verification
REQ-033 rst, start(mode=0), 3 ticks -> count=3, state=RUN, wrap=0.
REQ-034 load 8'd3, start(mode=1), 3 ticks -> count 2,1,0; done high one cycle on the third; state=DONE; a further tick leaves count=0.
REQ-035 RUN at count=7, stop and tick in the same cycle -> state=PAUSE, count=7; start -> RUN, next tick gives 8.
REQ-036 Undefined macro: load 8'd254, start up, 2 ticks -> count 255 then 0, wrap pulsed once; defined macro with LIMIT=59: load 8'd59, start, 1 tick -> count 0, wrap pulsed.
REQ-037 RUN at count=40, rst together with tick -> count=0, state=IDLE, done=0, wrap=0.
REQ-038 load 8'd0, start mode=1 -> state=DONE and done pulsed one cycle; load during RUN ignored.
